// File: rtl/complex_fir_controller.sv
// Sequencer between a sample source and a complex FIR plus its coefficient
// setup block. It requests the coefficient load, then streams a handshaked
// burst into the FIR. After the burst it appends LENGTH-1 zero samples for the
// full convolution, waits out the FIR latency and marks the valid FIR output
// cycles.
module complex_fir_controller #(
  parameter int LENGTH        = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int COEFF_TIMEOUT = 64,
  parameter int FIR_LATENCY   = 1
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         start,
  input  logic                         inValid,
  input  logic signed [DATA_WIDTH-1:0] inRe,
  input  logic signed [DATA_WIDTH-1:0] inIm,
  input  logic                         inLast,
  output logic                         inReady,
  input  logic                         coeffSetFlag,
  output logic                         loadCoefficients,
  output logic                         loadDataFlag,
  output logic                         stopDataLoadFlag,
  output logic signed [DATA_WIDTH-1:0] firDataRe,
  output logic signed [DATA_WIDTH-1:0] firDataIm,
  output logic                         outValid,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int TMO_W = $clog2(COEFF_TIMEOUT) + 1;
  localparam int PAD_W = $clog2(LENGTH - 1) + 1;
  localparam int FLS_W = $clog2(FIR_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_COEFF,
    S_STREAM,
    S_PAD,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Registered outputs and their next values.
  logic                         r_in_ready,  w_in_ready;
  logic                         r_load_coef, w_load_coef;
  logic                         r_load_data, w_load_data;
  logic                         r_stop,      w_stop;
  logic signed [DATA_WIDTH-1:0] r_fir_re,    w_fir_re;
  logic signed [DATA_WIDTH-1:0] r_fir_im,    w_fir_im;
  logic                         r_busy,      w_busy;
  logic                         r_done,      w_done;
  logic                         r_error,     w_error;

  // Internal counters.
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
  logic [PAD_W-1:0] r_pad_cnt, w_pad_cnt;
  logic [FLS_W-1:0] r_fls_cnt, w_fls_cnt;
  logic [15:0]      r_smp_cnt, w_smp_cnt;

  logic [FIR_LATENCY-1:0] r_vpipe;
  logic                   w_accept;
  logic                   w_consume;

  assign w_accept  = inValid & r_in_ready;
  assign w_consume = r_load_data & ~r_stop;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state plus next value of every registered output and counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned (which would infer a latch).
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_load_coef  = 1'b0;
    w_load_data  = 1'b0;
    w_stop       = 1'b0;
    w_fir_re     = r_fir_re;
    w_fir_im     = r_fir_im;
    w_done       = 1'b0;
    w_error      = r_error;
    w_tmo_cnt    = r_tmo_cnt;
    w_pad_cnt    = r_pad_cnt;
    w_fls_cnt    = r_fls_cnt;
    w_smp_cnt    = r_smp_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD_COEFF;
          w_load_coef  = 1'b1;
          w_error      = 1'b0;
          w_tmo_cnt    = '0;
          w_smp_cnt    = '0;
        end
      end

      S_LOAD_COEFF: begin
        // The flag takes priority over a timeout in the same cycle.
        if (coeffSetFlag) begin
          w_next_state = S_STREAM;
          w_load_data  = 1'b1;
          w_in_ready   = 1'b1;
          w_stop       = 1'b1;   // no sample accepted yet, so the FIR must not shift
        end else if (r_tmo_cnt == TMO_W'(COEFF_TIMEOUT - 1)) begin
          w_next_state = S_IDLE;
          w_error      = 1'b1;
        end else begin
          w_load_coef  = 1'b1;
          w_tmo_cnt    = r_tmo_cnt + 1'b1;
        end
      end

      S_STREAM: begin
        w_load_data = 1'b1;
        if (w_accept) begin
          w_fir_re  = inRe;
          w_fir_im  = inIm;
          w_smp_cnt = (r_smp_cnt == 16'hFFFF) ? r_smp_cnt : r_smp_cnt + 1'b1;
          if (inLast) begin
            w_next_state = (LENGTH > 1) ? S_PAD : S_FLUSH;
            w_pad_cnt    = '0;
            w_fls_cnt    = '0;
          end else begin
            w_in_ready = 1'b1;
          end
        end else begin
          // A gap stalls the FIR so it does not affect the convolution.
          w_stop     = 1'b1;
          w_in_ready = 1'b1;
        end
      end

      S_PAD: begin
        // Each cycle schedules one zero sample; the last one is scheduled
        // as the state moves on to FLUSH.
        w_load_data = 1'b1;
        w_fir_re    = '0;
        w_fir_im    = '0;
        if (r_pad_cnt == PAD_W'(LENGTH - 2)) begin
          w_next_state = S_FLUSH;
          w_fls_cnt    = '0;
        end else begin
          w_pad_cnt = r_pad_cnt + 1'b1;
        end
      end

      S_FLUSH: begin
        // Hold the FIR frozen for its latency, then report completion.
        if (r_fls_cnt == FLS_W'(FIR_LATENCY)) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_load_data = 1'b1;
          w_stop      = 1'b1;
          w_fls_cnt   = r_fls_cnt + 1'b1;
        end
      end

      default: w_next_state = S_IDLE;
    endcase

    w_busy = (w_next_state != S_IDLE);
  end

  // Output and counter registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_in_ready  <= 1'b0;
      r_load_coef <= 1'b0;
      r_load_data <= 1'b0;
      r_stop      <= 1'b0;
      r_fir_re    <= '0;
      r_fir_im    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_tmo_cnt   <= '0;
      r_pad_cnt   <= '0;
      r_fls_cnt   <= '0;
      r_smp_cnt   <= '0;
    end else begin
      r_in_ready  <= w_in_ready;
      r_load_coef <= w_load_coef;
      r_load_data <= w_load_data;
      r_stop      <= w_stop;
      r_fir_re    <= w_fir_re;
      r_fir_im    <= w_fir_im;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
      r_tmo_cnt   <= w_tmo_cnt;
      r_pad_cnt   <= w_pad_cnt;
      r_fls_cnt   <= w_fls_cnt;
      r_smp_cnt   <= w_smp_cnt;
    end
  end

  // Delay each FIR consume cycle by the FIR latency to mark valid outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_consume;
      for (int i = 1; i < FIR_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];
    end
  end

  assign inReady          = r_in_ready;
  assign loadCoefficients = r_load_coef;
  assign loadDataFlag     = r_load_data;
  assign stopDataLoadFlag = r_stop;
  assign firDataRe        = r_fir_re;
  assign firDataIm        = r_fir_im;
  assign outValid         = r_vpipe[FIR_LATENCY-1];
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;

endmodule

// File: tb/tb_complex_fir_controller.sv
// Directed bench for complex_fir_controller. Expected FIR input samples are
// queued as the source drives them and popped when the FIR consumes a sample.
module tb_complex_fir_controller;

  localparam int LENGTH        = 12;
  localparam int DATA_WIDTH    = 8;
  localparam int COEFF_TIMEOUT = 64;
  localparam int FIR_LATENCY   = 1;
  localparam int NSMP          = 28;

  logic                         clock = 1'b0;
  logic                         resetN;
  logic                         start;
  logic                         inValid;
  logic signed [DATA_WIDTH-1:0] inRe;
  logic signed [DATA_WIDTH-1:0] inIm;
  logic                         inLast;
  logic                         inReady;
  logic                         coeffSetFlag;
  logic                         loadCoefficients;
  logic                         loadDataFlag;
  logic                         stopDataLoadFlag;
  logic signed [DATA_WIDTH-1:0] firDataRe;
  logic signed [DATA_WIDTH-1:0] firDataIm;
  logic                         outValid;
  logic                         busy;
  logic                         done;
  logic                         error;

  complex_fir_controller #(
    .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH),
    .COEFF_TIMEOUT(COEFF_TIMEOUT), .FIR_LATENCY(FIR_LATENCY)
  ) dut (
    .clock(clock), .resetN(resetN), .start(start), .inValid(inValid),
    .inRe(inRe), .inIm(inIm), .inLast(inLast), .inReady(inReady),
    .coeffSetFlag(coeffSetFlag), .loadCoefficients(loadCoefficients),
    .loadDataFlag(loadDataFlag), .stopDataLoadFlag(stopDataLoadFlag),
    .firDataRe(firDataRe), .firDataIm(firDataIm), .outValid(outValid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0]                  sb[$];
  logic [15:0]                  last_exp;
  logic signed [DATA_WIDTH-1:0] smp_re[NSMP];
  logic signed [DATA_WIDTH-1:0] smp_im[NSMP];

  int n_outvalid = 0, n_done = 0, n_loadcoef = 0, n_ld = 0;
  int cyc_now = 0, last_ov_cyc = 0, done_cyc = 0;
  bit prev_ready = 0, prev_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {inReady, loadCoefficients, loadDataFlag, stopDataLoadFlag,
                firDataRe, firDataIm, outValid, busy, done, error}, 32'd0);
  endtask

  // Per-cycle observation at the falling edge: scoreboard and event counters.
  task automatic monitor();
    logic [15:0] exp;
    cyc_now++;
    if (prev_ready) check("stall_flag", stopDataLoadFlag, !prev_acc);
    if (loadDataFlag) begin
      n_ld++;
      if (!stopDataLoadFlag) begin
        n_chk++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed=fir %0h expected=a queued sample", {firDataRe, firDataIm});
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          last_exp = exp;
          check("fir_data", {firDataRe, firDataIm}, exp);
        end
      end else begin
        check("fir_hold", {firDataRe, firDataIm}, last_exp);
      end
    end
    if (outValid) begin n_outvalid++; last_ov_cyc = cyc_now; end
    if (done) begin n_done++; done_cyc = cyc_now; end
    if (loadCoefficients) n_loadcoef++;
    prev_ready = inReady;
    prev_acc   = inValid & inReady;
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clock);
    if (resetN) monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic run_burst(input int n, input bit gap, input int flag_delay,
                           input bit start_mid, input int abort_pad);
    int  oc0, dn0, lc0, idx, cyc, since;
    bit  fin;
    oc0 = n_outvalid; dn0 = n_done; lc0 = n_loadcoef;
    sb.delete();
    last_exp = '0;

    start = 1'b1;
    cycle();
    start = 1'b0;
    check("lc_after_start", loadCoefficients, 1);
    check("busy_after_start", busy, 1);
    check("err_cleared", error, 0);

    for (int c = 1; c <= flag_delay; c++) begin
      coeffSetFlag = (c == flag_delay);
      cycle();
    end
    coeffSetFlag = 1'b0;
    check("ready_in_stream", inReady, 1);
    check("lc_off_in_stream", loadCoefficients, 0);

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      if (gap && (cyc % 3 == 2)) begin
        inValid = 1'b0;
      end else begin
        inValid = 1'b1;
        inRe    = smp_re[idx];
        inIm    = smp_im[idx];
        inLast  = (idx == n - 1);
      end
      start = (start_mid && cyc == 2);
      if (inValid && inReady) begin
        sb.push_back({inRe, inIm});
        if (inLast) for (int z = 0; z < LENGTH - 1; z++) sb.push_back(16'h0000);
        idx++;
      end
      cycle();
      cyc++;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    start   = 1'b0;
    check("stream_accepts", idx, n);
    check("ready_drop", inReady, 0);

    since = 0;
    fin   = 0;
    while (!fin && since < 200) begin
      if (abort_pad != 0 && since == abort_pad) begin
        resetN = 1'b0;
        #1;
        check_all_zero("abort_outs");
        check("abort_no_done", n_done - dn0, 0);
        fin = 1;
      end else begin
        cycle();
        since++;
        if (n_done != dn0) fin = 1;
      end
    end
    check("burst_end_reached", fin, 1);

    if (abort_pad == 0) begin
      check("done_pulse_once", n_done - dn0, 1);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      check("outvalid_cnt", n_outvalid - oc0, n + LENGTH - 1);
      check("ov_before_done", last_ov_cyc <= done_cyc, 1);
      check("lc_cycles", n_loadcoef - lc0, flag_delay);
      check("sb_drained", sb.size(), 0);
      check("error_clear", error, 0);
    end
  endtask

  initial begin
    int k, lc0, ld0, dn0;
    resetN = 1'b0; start = 1'b0; inValid = 1'b0; inRe = '0; inIm = '0;
    inLast = 1'b0; coeffSetFlag = 1'b0;

    for (int i = 0; i < NSMP; i++) begin
      smp_re[i] = 8'(((i * 29) % 181) - 90);
      smp_im[i] = 8'(95 - ((i * 41) % 191));
    end
    smp_re[0] = 8'sd2;   smp_im[0] = 8'sd3;
    smp_re[1] = 8'sd5;   smp_im[1] = 8'sd10;
    smp_re[2] = -8'sd2;  smp_im[2] = -8'sd3;
    smp_re[NSMP-1] = 8'sd90; smp_im[NSMP-1] = -8'sd96;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset_outs");
    resetN = 1'b1;
    cycle();
    check_all_zero("idle_outs");

    // Nominal burst, then the same burst with periodic gaps.
    run_burst(NSMP, 0, 20, 0, 0);
    run_burst(NSMP, 1, 20, 0, 0);

    // Coefficient timeout, then a fresh start clears the sticky error.
    lc0 = n_loadcoef; ld0 = n_ld; dn0 = n_done;
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 0;
    while (!error && k < 100) begin cycle(); k++; end
    check("tmo_error", error, 1);
    check("tmo_lc_cycles", n_loadcoef - lc0, COEFF_TIMEOUT);
    check("tmo_idle", busy, 0);
    repeat (3) cycle();
    check("tmo_sticky", error, 1);
    check("tmo_no_ld", n_ld - ld0, 0);
    check("tmo_no_done", n_done - dn0, 0);
    run_burst(3, 0, 5, 0, 0);

    // Single-sample burst 7-4j.
    smp_re[0] = 8'sd7; smp_im[0] = -8'sd4;
    run_burst(1, 0, 20, 0, 0);
    smp_re[0] = 8'sd2; smp_im[0] = 8'sd3;

    // Reset during the fifth pad cycle aborts without a done pulse.
    run_burst(NSMP, 0, 20, 0, 5);
    sb.delete();
    prev_ready = 0;
    prev_acc   = 0;
    cycle();
    cycle();
    resetN = 1'b1;
    cycle();
    check_all_zero("post_abort_idle");

    // Full burst after reset, start pulsed mid-stream, flag on the last
    // allowed load cycle.
    run_burst(NSMP, 0, COEFF_TIMEOUT, 1, 0);
    repeat (3) cycle();
    check("start_mid_ignored", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/complex_fir_controller.md
Name: complex_fir_controller

Overview:
Sequencer for the complex n-tap FIR and its coefficient setup block. On a start pulse it requests the coefficient load and waits for the set flag. It then streams a handshaked complex sample burst into the FIR, appends LENGTH-1 zero samples for full convolution, and flags which FIR output cycles are valid. It replaces hand-written stimulus sequencing with a reusable block sitting between the sample source and the FIR/coeff-setup pair.

Parameters:
LENGTH, 12, number of FIR taps; sets zero-pad count LENGTH-1
DATA_WIDTH, 8, signed width of each real/imag sample
COEFF_TIMEOUT, 64, max cycles in LOAD_COEFF waiting for coeffSetFlag
FIR_LATENCY, 1, clock cycles from FIR input register to a valid dataOutRe/Im

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run a burst; honoured only in IDLE
inValid  in  1  source sample valid
inRe  in  DATA_WIDTH  signed real part of the source sample
inIm  in  DATA_WIDTH  signed imaginary part of the source sample
inLast  in  1  qualifies the final sample of the burst (with inValid)
inReady  out  1  controller accepts a sample this cycle
coeffSetFlag  in  1  from coeff setup/FIR: coefficients are loaded
loadCoefficients  out  1  enable to the coeff setup block and the FIR
loadDataFlag  out  1  FIR data-load enable
stopDataLoadFlag  out  1  freezes the FIR shift register for the current cycle
firDataRe  out  DATA_WIDTH  registered real sample to the FIR
firDataIm  out  DATA_WIDTH  registered imaginary sample to the FIR
outValid  out  1  FIR dataOutRe/Im holds a valid convolution term this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at successful burst end
error  out  1  sticky coefficient timeout; cleared by the next accepted start

Behaviour:
- Reset (resetN=0, async): state IDLE; all outputs 0; counters 0; outValid delay line cleared. Reset mid-burst aborts immediately, with no done pulse.
- States: IDLE, LOAD_COEFF, STREAM, PAD, FLUSH. Every output is registered.
- IDLE: start=1 → LOAD_COEFF, clears error. inValid is ignored (inReady=0). start in any other state is ignored.
- LOAD_COEFF: loadCoefficients=1 and the timeout counter increments each cycle.
  - coeffSetFlag=1 → loadCoefficients=0 next cycle, go to STREAM.
  - Counter reaching COEFF_TIMEOUT with no flag → error=1, go to IDLE.
  - If flag and timeout occur in the same cycle, the flag wins.
- STREAM: loadDataFlag=1, inReady=1.
  - Accept when inValid&inReady. Next cycle: firDataRe/Im = inRe/inIm, stopDataLoadFlag=0.
  - No accept in a cycle → next cycle firData holds its previous value, stopDataLoadFlag=1 (FIR stalls, so gaps do not alter the convolution).
  - Accepted sample with inLast=1 → PAD. inReady drops in that same transition, so inReady is 0 in the first PAD cycle.
- PAD: inReady=0; firDataRe/Im=0; stopDataLoadFlag=0 for exactly LENGTH-1 consecutive cycles (pad counter), then FLUSH.
- FLUSH: loadDataFlag stays 1 and stopDataLoadFlag=1 for FIR_LATENCY cycles. Then loadDataFlag=0, done=1 for one cycle, go to IDLE.
- outValid: marks every cycle in which the FIR consumed a sample (loadDataFlag=1 & stopDataLoadFlag=0), delayed by FIR_LATENCY cycles through a shift register.
  - For an N-sample burst, total outValid cycles = N+LENGTH-1 exactly.
  - The last outValid cycle coincides with or precedes the done pulse.
- Counters: sample count is 16 bits and not exported. Timeout and pad counter widths are $clog2 of the respective limit +1.
- Arithmetic: none; samples are passed through sign-preserving, not modified.
- busy = (state != IDLE).

Test Plan:
- Nominal: start; coeffSetFlag after 20 cycles; 28 contiguous samples (2+3j, 5+10j, −2−3j, …, 90−96j), inLast on the 28th → loadCoefficients high for 20 cycles; firData matches the input sequence then 11 zeros; outValid count 39; one done pulse; error=0.
- Gapped input: same 28 samples with inValid low every 3rd cycle → stopDataLoadFlag=1 exactly on gap cycles; firData held during gaps; outValid count still 39; FIR output identical to the nominal run.
- Coefficient timeout: start, coeffSetFlag held 0 → after 64 cycles error=1, state IDLE, loadDataFlag never asserted, no done. A new start clears error.
- Single sample: 7−4j with inLast on the first beat → 1 data cycle + 11 pad cycles, outValid count 12, done once.
- Reset mid-PAD: assert resetN=0 during the 5th pad cycle → all outputs 0 asynchronously, no done. After release, start runs a full nominal burst correctly.
- Start while busy plus same-cycle flag/timeout: pulse start during STREAM → ignored. coeffSetFlag on cycle 64 → proceeds to STREAM with error=0.
